// File: rtl/wm8731_i2s_tx.sv
// wm8731_i2s_tx: I2S bus master that drains {left,right} words from an async FIFO read port.
// Define WM8731_TX_UNDERRUN_REPEAT_EN to repeat the last frame on underrun instead of silence.
`timescale 1ns/1ps
module wm8731_i2s_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_DIV     = 2
) (
    input  logic                      Clk,
    input  logic                      Reset_n_in,
    input  logic                      Enable_in,
    input  logic [2*SAMPLE_WIDTH-1:0] FifoData_in,
    input  logic                      FifoEmpty_in,
    output logic                      FifoReadEn_out,
    input  logic                      UnderrunClear_in,
    output logic                      Bclk_out,
    output logic                      Lrclk_out,
    output logic                      Dacdat_out,
    output logic                      Underrun_out,
    output logic                      Busy_out,
    output logic [1:0]                DbgState_out
);
    localparam int WORD_W     = 2 * SAMPLE_WIDTH;
    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_L   = BIT_W'(SLOT_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    divcnt_q, divcnt_d;
    logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
    logic                bclk_q, bclk_d;
    logic [WORD_W-1:0]   frame_q, frame_d;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic                underrun_q, underrun_d;

    logic                pop;
    logic                underrun_set;
    logic                tick;
    logic                rise_tick;
    logic                fall_tick;
    logic [WORD_W-1:0]   fill;

    always_ff @(posedge Clk or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            state_q    <= ST_IDLE;
            divcnt_q   <= '0;
            bitcnt_q   <= '0;
            bclk_q     <= 1'b0;
            frame_q    <= '0;
            hold_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            divcnt_q   <= divcnt_d;
            bitcnt_q   <= bitcnt_d;
            bclk_q     <= bclk_d;
            frame_q    <= frame_d;
            hold_q     <= hold_d;
            underrun_q <= underrun_d;
        end
    end

    // FifoReadEn_out is a one-Clk pop strobe raised only while FifoEmpty_in is low;
    // FifoData_in is captured on the same rising edge that ends the strobe cycle.
    always_comb begin
        state_d      = state_q;
        divcnt_d     = divcnt_q;
        bitcnt_d     = bitcnt_q;
        bclk_d       = bclk_q;
        frame_d      = frame_q;
        hold_d       = hold_q;
        pop          = 1'b0;
        underrun_set = 1'b0;
        tick         = (divcnt_q == DIV_LAST);
        rise_tick    = tick && !bclk_q;
        fall_tick    = tick && bclk_q;
`ifdef WM8731_TX_UNDERRUN_REPEAT_EN
        fill         = frame_q;
`else
        fill         = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Enable_in) state_d = ST_START;
            end
            ST_START: begin
                if (!FifoEmpty_in) begin
                    pop     = 1'b1;
                    frame_d = FifoData_in;
                end else begin
                    frame_d      = fill;
                    underrun_set = 1'b1;
                end
                divcnt_d = '0;
                bitcnt_d = '0;
                bclk_d   = 1'b0;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                divcnt_d = tick ? '0 : divcnt_q + DIV_W'(1);
                if (tick) bclk_d = !bclk_q;
                // Next frame is fetched half a BCLK before the wrap so it is ready at the boundary.
                if (rise_tick && bitcnt_q == BIT_LAST) begin
                    if (!FifoEmpty_in) begin
                        pop    = 1'b1;
                        hold_d = FifoData_in;
                    end else begin
                        hold_d       = fill;
                        underrun_set = 1'b1;
                    end
                end
                if (fall_tick) begin
                    if (bitcnt_q == BIT_LAST) begin
                        bitcnt_d = '0;
                        frame_d  = hold_q;
                        if (!Enable_in) begin
                            state_d  = ST_IDLE;
                            divcnt_d = '0;
                            bclk_d   = 1'b0;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        underrun_d = underrun_set || (underrun_q && !UnderrunClear_in);
    end

    logic                    run;
    logic                    lr;
    logic [BIT_W-1:0]        pos;
    logic [SAMPLE_WIDTH-1:0] sample;
    logic                    dat;

    // Slot position 0 carries the I2S one-bit delay; positions past the sample are padding.
    always_comb begin
        run    = (state_q == ST_RUN);
        lr     = (bitcnt_q >= SLOT_L);
        pos    = lr ? (bitcnt_q - SLOT_L) : bitcnt_q;
        sample = lr ? frame_q[SAMPLE_WIDTH-1:0] : frame_q[WORD_W-1:SAMPLE_WIDTH];
        dat    = 1'b0;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            if (pos == BIT_W'(SAMPLE_WIDTH - i)) dat = sample[i];
        end
    end

    assign FifoReadEn_out = pop;
    assign Bclk_out       = run && bclk_q;
    assign Lrclk_out      = run && lr;
    assign Dacdat_out     = run && dat;
    assign Underrun_out   = underrun_q;
    assign Busy_out       = (state_q != ST_IDLE);
    assign DbgState_out   = state_q;

endmodule

// File: tb/tb_wm8731_i2s_tx.sv
// Bench for wm8731_i2s_tx: default instance plus a BCLK_DIV=1 / SLOT_WIDTH=17 instance,
// each checked every cycle against a frame-arithmetic model and by directed sequences.
`timescale 1ns/1ps
module tb_wm8731_i2s_tx;
    localparam int DA = 2;
    localparam int SA = 32;
    localparam int DB = 1;
    localparam int SB = 17;
    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_START = 2'd1;
    localparam logic [1:0] M_RUN   = 2'd2;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] c;
        logic [31:0] frame;
        logic [31:0] hold;
        logic        und;
    } mdl_t;

    typedef struct packed {
        logic [31:0] word;
        logic [63:0] image;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        en_a = 1'b0, empty_a = 1'b1, clr_a = 1'b0;
    logic [31:0] data_a = 32'h0;
    logic        pop_a, bclk_a, lr_a, dat_a, und_a, busy_a;
    logic [1:0]  dbg_a;
    logic        en_b = 1'b0, empty_b = 1'b1, clr_b = 1'b0;
    logic [31:0] data_b = 32'h0;
    logic        pop_b, bclk_b, lr_b, dat_b, und_b, busy_b;
    logic [1:0]  dbg_b;

    wm8731_i2s_tx dut_a (
        .Clk(clk), .Reset_n_in(rst_n), .Enable_in(en_a), .FifoData_in(data_a),
        .FifoEmpty_in(empty_a), .FifoReadEn_out(pop_a), .UnderrunClear_in(clr_a),
        .Bclk_out(bclk_a), .Lrclk_out(lr_a), .Dacdat_out(dat_a), .Underrun_out(und_a),
        .Busy_out(busy_a), .DbgState_out(dbg_a)
    );

    wm8731_i2s_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(SB), .BCLK_DIV(DB)) dut_b (
        .Clk(clk), .Reset_n_in(rst_n), .Enable_in(en_b), .FifoData_in(data_b),
        .FifoEmpty_in(empty_b), .FifoReadEn_out(pop_b), .UnderrunClear_in(clr_b),
        .Bclk_out(bclk_b), .Lrclk_out(lr_b), .Dacdat_out(dat_b), .Underrun_out(und_b),
        .Busy_out(busy_b), .DbgState_out(dbg_b)
    );

    logic [5:0] obs_a, obs_b, exp_a, exp_b;
    assign obs_a = {busy_a, pop_a, bclk_a, lr_a, dat_a, und_a};
    assign obs_b = {busy_b, pop_b, bclk_b, lr_b, dat_b, und_b};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: output of a cycle derived from elapsed cycles since RUN began
    function automatic logic [5:0] mdl_out(mdl_t m, int d, int s, logic empty);
        int n, ph, b, p;
        logic [15:0] smp;
        logic bclk, lr, dat, pop;
        bclk = 1'b0; lr = 1'b0; dat = 1'b0; pop = 1'b0;
        if (m.st == M_START) begin
            pop = !empty;
        end else if (m.st == M_RUN) begin
            n  = int'(m.c) / (2 * d);
            ph = int'(m.c) % (2 * d);
            b  = n % (2 * s);
            bclk = (ph >= d);
            lr   = (b >= s);
            p    = b % s;
            smp  = lr ? m.frame[15:0] : m.frame[31:16];
            if (p >= 1 && p <= 16) dat = smp[16 - p];
            pop = (b == 2 * s - 1) && (ph == d - 1) && !empty;
        end
        return {m.st != M_IDLE, pop, bclk, lr, dat, m.und};
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, int d, int s, logic en, logic empty,
                                      logic clr, logic [31:0] data);
        mdl_t r;
        int n, ph, b;
        logic [31:0] fill;
        r = m;
`ifdef WM8731_TX_UNDERRUN_REPEAT_EN
        fill = m.frame;
`else
        fill = 32'h0;
`endif
        if (clr) r.und = 1'b0;
        if (m.st == M_IDLE) begin
            if (en) r.st = M_START;
        end else if (m.st == M_START) begin
            r.frame = empty ? fill : data;
            if (empty) r.und = 1'b1;
            r.c  = 16'd0;
            r.st = M_RUN;
        end else begin
            n  = int'(m.c) / (2 * d);
            ph = int'(m.c) % (2 * d);
            b  = n % (2 * s);
            if (b == 2 * s - 1 && ph == d - 1) begin
                r.hold = empty ? fill : data;
                if (empty) r.und = 1'b1;
            end
            if (b == 2 * s - 1 && ph == 2 * d - 1) begin
                r.frame = m.hold;
                r.c = 16'd0;
                if (!en) r.st = M_IDLE;
            end else begin
                r.c = m.c + 16'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] image(logic [31:0] w);
        return {1'b0, w[31:16], 15'h0, 1'b0, w[15:0], 15'h0};
    endfunction

    // FIFO emulation and scoreboards
    logic [31:0] qa[$], qb[$];
    logic [63:0] rx_a[$];
    int          pop_cyc_a[$], pop_cyc_b[$];
    int          pops_a = 0, pops_b = 0;
    logic        pop_seen_a = 1'b0, pop_seen_b = 1'b0;
    mdl_t        ma = '0, mb = '0;
    logic [63:0] sh_a = 64'h0;
    int          rises_a = 0;
    logic        prev_bclk_a = 1'b0;

    task automatic refresh_a();
        empty_a = (qa.size() == 0);
        data_a  = empty_a ? $urandom() : qa[0];
    endtask

    task automatic refresh_b();
        empty_b = (qb.size() == 0);
        data_b  = empty_b ? $urandom() : qb[0];
    endtask

    always @(posedge clk) begin
        #1;
        if (pop_seen_a && qa.size() > 0) void'(qa.pop_front());
        if (pop_seen_b && qb.size() > 0) void'(qb.pop_front());
        refresh_a();
        refresh_b();
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outs_a", obs_a, 64'h0);
            ma = '0; pop_seen_a = 1'b0; rises_a = 0; prev_bclk_a = 1'b0;
        end else begin
            exp_a = mdl_out(ma, DA, SA, empty_a);
            chk($sformatf("cycle_a@%0d {busy,pop,bclk,lr,dat,und}", cyc), obs_a, exp_a);
            pop_seen_a = pop_a;
            if (pop_a) begin
                pops_a++;
                pop_cyc_a.push_back(cyc);
            end
            ma = mdl_next(ma, DA, SA, en_a, empty_a, clr_a, data_a);
            if (!busy_a) begin
                rises_a = 0;
            end else if (bclk_a && !prev_bclk_a) begin
                sh_a = {sh_a[62:0], dat_a};
                rises_a++;
                if (rises_a == 64) begin
                    rx_a.push_back(sh_a);
                    rises_a = 0;
                end
            end
            prev_bclk_a = bclk_a;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outs_b", obs_b, 64'h0);
            mb = '0; pop_seen_b = 1'b0;
        end else begin
            exp_b = mdl_out(mb, DB, SB, empty_b);
            chk($sformatf("cycle_b@%0d {busy,pop,bclk,lr,dat,und}", cyc), obs_b, exp_b);
            pop_seen_b = pop_b;
            if (pop_b) begin
                pops_b++;
                pop_cyc_b.push_back(cyc);
            end
            mb = mdl_next(mb, DB, SB, en_b, empty_b, clr_b, data_b);
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_cycle(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic push_a(input logic [31:0] w);
        qa.push_back(w);
        refresh_a();
    endtask

    task automatic push_b(input logic [31:0] w);
        qb.push_back(w);
        refresh_b();
    endtask

    task automatic wait_pops_a(input int n, input int budget);
        while (pops_a < n && budget > 0) begin
            tick(1);
            budget--;
        end
        chk("pop_wait_a", 64'(pops_a >= n), 64'h1);
    endtask

    task automatic wait_pops_b(input int n, input int budget);
        while (pops_b < n && budget > 0) begin
            tick(1);
            budget--;
        end
        chk("pop_wait_b", 64'(pops_b >= n), 64'h1);
    endtask

    task automatic wait_idle_a(input int budget);
        while (busy_a && budget > 0) begin
            tick(1);
            budget--;
        end
        chk("idle_wait_a", 64'(busy_a), 64'h0);
    endtask

    task automatic wait_idle_b(input int budget);
        while (busy_b && budget > 0) begin
            tick(1);
            budget--;
        end
        chk("idle_wait_b", 64'(busy_b), 64'h0);
    endtask

    vec_t vecs[4];
    int   s;

    initial begin
        vecs[0] = '{word: 32'hA5A5_3C3C, image: {1'b0, 16'hA5A5, 15'h0, 1'b0, 16'h3C3C, 15'h0}};
        vecs[1] = '{word: 32'h1234_5678, image: {1'b0, 16'h1234, 15'h0, 1'b0, 16'h5678, 15'h0}};
        vecs[2] = '{word: 32'hFFFF_0001, image: {1'b0, 16'hFFFF, 15'h0, 1'b0, 16'h0001, 15'h0}};
        vecs[3] = '{word: 32'h8000_FFFE, image: {1'b0, 16'h8000, 15'h0, 1'b0, 16'hFFFE, 15'h0}};

        refresh_a();
        refresh_b();
        tick(3);
        chk("reset_state_a", obs_a, 64'h0);
        chk("reset_state_b", obs_b, 64'h0);
        rst_n = 1'b1;
        tick(5);
        chk("idle_no_enable_a", obs_a, 64'h0);

        // stream of four frames, enable dropped around bit 10 of the last one
        for (int i = 0; i < 4; i++) push_a(vecs[i].word);
        push_a(32'hDEAD_BEEF);
        en_a = 1'b1;
        wait_pops_a(4, 2000);
        tick(44);
        en_a = 1'b0;
        wait_idle_a(400);
        chk("stream_frames", 64'(rx_a.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rx_a.size()) chk($sformatf("stream_frame%0d", i), rx_a[i], vecs[i].image);
        end
        chk("stream_pops", 64'(pops_a), 64'd5);
        if (pop_cyc_a.size() >= 5) begin
            chk("start_to_prefetch", 64'(pop_cyc_a[1] - pop_cyc_a[0]), 64'd254);
            for (int k = 1; k < 4; k++)
                chk($sformatf("pop_spacing%0d", k), 64'(pop_cyc_a[k+1] - pop_cyc_a[k]), 64'd256);
        end
        chk("stream_underrun", 64'(und_a), 64'h0);
        tick(300);
        chk("no_pops_after_stop", 64'(pops_a), 64'd5);
        chk("idle_outs_after_stop", obs_a, 64'h0);

        // underrun: one word only, then clear pulses off and on a prefetch cycle
        rx_a.delete();
        pop_cyc_a.delete();
        pops_a = 0;
        push_a(32'hA5A5_3C3C);
        en_a = 1'b1;
        wait_pops_a(1, 20);
        s = (pop_cyc_a.size() > 0) ? pop_cyc_a[0] : cyc;
        wait_cycle(s + 254);
        chk("underrun_before_prefetch", 64'(und_a), 64'h0);
        wait_cycle(s + 255);
        chk("underrun_set", 64'(und_a), 64'h1);
        wait_cycle(s + 400);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        chk("underrun_cleared", 64'(und_a), 64'h0);
        wait_cycle(s + 600);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        wait_cycle(s + 766);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        chk("underrun_set_wins", 64'(und_a), 64'h1);
        chk("underrun_frames", 64'(rx_a.size() >= 2), 64'h1);
        if (rx_a.size() >= 2) begin
            chk("underrun_frame0", rx_a[0], image(32'hA5A5_3C3C));
`ifdef WM8731_TX_UNDERRUN_REPEAT_EN
            chk("underrun_frame1", rx_a[1], image(32'hA5A5_3C3C));
`else
            chk("underrun_frame1", rx_a[1], 64'h0);
`endif
        end
        en_a = 1'b0;
        wait_idle_a(600);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        chk("underrun_idle_clear", 64'(und_a), 64'h0);

        // asynchronous reset mid-frame
        push_a(32'h0F0F_F0F0);
        push_a(32'h1111_2222);
        en_a = 1'b1;
        tick(100);
        chk("busy_before_reset", 64'(busy_a), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_a", obs_a, 64'h0);
        chk("async_reset_b", obs_b, 64'h0);
        qa.delete();
        refresh_a();
        en_a = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        chk("idle_after_reset", obs_a, 64'h0);

        // short-slot instance: no padding, 68-cycle frames
        pop_cyc_b.delete();
        pops_b = 0;
        push_b(32'hC0DE_8001);
        push_b(32'h7FFF_0003);
        push_b(32'h5A5A_A5A5);
        en_b = 1'b1;
        wait_pops_b(3, 300);
        en_b = 1'b0;
        if (pop_cyc_b.size() >= 3) begin
            chk("b_start_to_prefetch", 64'(pop_cyc_b[1] - pop_cyc_b[0]), 64'd67);
            chk("b_pop_spacing", 64'(pop_cyc_b[2] - pop_cyc_b[1]), 64'd68);
        end
        wait_idle_b(200);
        clr_b = 1'b1;
        tick(1);
        clr_b = 1'b0;

        // randomized traffic on both instances
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) en_a = ~en_a;
            if ($urandom_range(0, 99) == 0) en_b = ~en_b;
            if ($urandom_range(0, 179) == 0 && qa.size() < 4) push_a($urandom());
            if ($urandom_range(0, 59) == 0 && qb.size() < 4) push_b($urandom());
            clr_a = ($urandom_range(0, 63) == 0);
            clr_b = ($urandom_range(0, 31) == 0);
            tick(1);
        end
        en_a = 1'b0;
        en_b = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        wait_idle_a(600);
        wait_idle_b(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
